// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU between N_REQ requesters.
// One result register; a response is held until the consumer takes it.
module alu_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [2*N_REQ-1:0]   req_sel,
  input  logic [8*N_REQ-1:0]   req_op1,
  input  logic [8*N_REQ-1:0]   req_op2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic [CNT_W-1:0]     ops_done,
  output logic                 busy
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;

  logic              can_accept;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic [1:0]        sel_g;
  logic [7:0]        op1_g, op2_g;

  function automatic logic [7:0] alu(input logic [1:0] sel, input logic [7:0] a,
                                     input logic [7:0] b);
    logic [7:0] r;
    case (sel)
      2'b00:   r = a + b - 8'd3;
      2'b01:   r = a - b;
      2'b10:   r = a + 8'hAA;
      default: r = b - 8'hAA;
    endcase
    return r;
  endfunction

  // Grant search starts just after the last winner; gated off while in reset.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    req_ready   = '0;
    sel_g       = '0;
    op1_g       = '0;
    op2_g       = '0;
    can_accept  = (state_q == StIdle) | rsp_ready;
    if (can_accept && rst) begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        cand = ID_W'((32'(last_grant_q) + k) % N_REQ);
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_g = req_sel[2*i +: 2];
        op1_g = req_op1[8*i +: 8];
        op2_g = req_op2[8*i +: 8];
      end
    end
  end

  // A new grant in a completing cycle overrides the return to idle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    ops_done_d   = ops_done_q;
    if ((state_q == StResp) && rsp_ready) begin
      ops_done_d = ops_done_q + CNT_W'(1);
      state_d    = StIdle;
    end
    if (grant_found) begin
      state_d      = StResp;
      last_grant_d = grant_idx;
      rsp_id_d     = grant_idx;
      rsp_data_d   = alu(sel_g, op1_g, op2_g);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= ID_W'(N_REQ - 1);
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign busy      = rsp_valid;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign ops_done  = ops_done_q;

endmodule
